id_issue_stage: RTL and testbench

Parametrised decode-to-execute issue stage for the in-order MIPS pipeline, sitting between the instruction decoder and EXE. It latches the decoded instruction bundle into the ID/EXE pipeline register and resolves operands through a configurable number of prioritised bypass sources. It adds three things the fixed-width ID stage lacks: a load-use interlock, downstream backpressure, and a serialisation drain sequencer with a parametrised bubble depth (syscall / LL / SC).

---
 rtl/id_issue_stage.sv | 132 +++++++++++++
 tb/tb_id_issue_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_stage.sv
// ID/EXE issue stage: latches the decoded bundle, resolves operands through prioritised
// bypass sources, and sequences load-use, backpressure and serialising-drain bubbles.
module id_issue_stage #(
  parameter int DATA_W  = 32,
  parameter int NUM_BYP = 3,
  parameter int DRAIN   = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      in_valid,
  input  logic [31:0]               in_instr,
  input  logic [DATA_W-1:0]         in_pc,
  input  logic [4:0]                in_rs,
  input  logic [4:0]                in_rt,
  input  logic [4:0]                in_wreg,
  input  logic                      in_uses_rs,
  input  logic                      in_uses_rt,
  input  logic                      in_regwrite,
  input  logic                      in_memread,
  input  logic                      in_serialize,
  input  logic [DATA_W-1:0]         rf_rs_data,
  input  logic [DATA_W-1:0]         rf_rt_data,
  input  logic [5*NUM_BYP-1:0]      byp_reg,
  input  logic [DATA_W*NUM_BYP-1:0] byp_data,
  input  logic [NUM_BYP-1:0]        byp_valid,
  input  logic                      exe_ready,
  input  logic                      flush,
  output logic                      stall,
  output logic                      out_valid,
  output logic                      out_regwrite,
  output logic                      out_memread,
  output logic [31:0]               out_instr,
  output logic [DATA_W-1:0]         out_pc,
  output logic [DATA_W-1:0]         out_opa,
  output logic [DATA_W-1:0]         out_opb,
  output logic [4:0]                out_wreg,
  output logic                      sys_pulse
);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  localparam logic [3:0] DRAIN_CNT = 4'(DRAIN);

  state_t            state;
  logic [3:0]        counter;
  logic [DATA_W-1:0] opa_sel;
  logic [DATA_W-1:0] opb_sel;
  logic              hazard;
  logic              accept;

  // Walk from lowest to highest priority so the lowest matching index ends up winning.
  always_comb begin
    opa_sel = rf_rs_data;
    opb_sel = rf_rt_data;
    for (int i = NUM_BYP - 1; i >= 0; i--) begin
      if (byp_valid[i] && (byp_reg[5*i +: 5] == in_rs))
        opa_sel = byp_data[DATA_W*i +: DATA_W];
      if (byp_valid[i] && (byp_reg[5*i +: 5] == in_rt))
        opb_sel = byp_data[DATA_W*i +: DATA_W];
    end
    if (in_rs == 5'd0)
      opa_sel = '0;
    if (in_rt == 5'd0)
      opb_sel = '0;
  end

  assign hazard = out_valid && out_memread && (out_wreg != 5'd0) &&
                  ((in_uses_rs && (in_rs == out_wreg)) ||
                   (in_uses_rt && (in_rt == out_wreg)));

  assign accept = in_valid && exe_ready && !hazard && (state == S_IDLE) && !flush;

  assign stall = !exe_ready || hazard || (state == S_DRAIN);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid    <= 1'b0;
      out_regwrite <= 1'b0;
      out_memread  <= 1'b0;
      out_instr    <= '0;
      out_pc       <= '0;
      out_opa      <= '0;
      out_opb      <= '0;
      out_wreg     <= '0;
      sys_pulse    <= 1'b0;
      state        <= S_IDLE;
      counter      <= '0;
    end else begin
      sys_pulse <= 1'b0;
      if (flush) begin
        out_valid <= 1'b0;
        state     <= S_IDLE;
        counter   <= '0;
      end else if (exe_ready) begin
        if (accept) begin
          out_valid    <= 1'b1;
          out_regwrite <= in_regwrite && (in_wreg != 5'd0);
          out_memread  <= in_memread;
          out_instr    <= in_instr;
          out_pc       <= in_pc;
          out_opa      <= opa_sel;
          out_opb      <= opb_sel;
          out_wreg     <= in_wreg;
        end else begin
          out_valid    <= 1'b0;
          out_regwrite <= 1'b0;
          out_memread  <= 1'b0;
        end

        // The pulse fires one cycle before the drain's final bubble.
        case (state)
          S_IDLE: begin
            if (accept && in_serialize) begin
              state   <= S_DRAIN;
              counter <= DRAIN_CNT;
            end
          end
          S_DRAIN: begin
            if (counter == 4'd2)
              sys_pulse <= 1'b1;
            if (counter != 4'd0)
              counter <= counter - 4'd1;
            if (counter <= 4'd1)
              state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: bypass priority, load-use, drain, backpressure,
// flush and asynchronous reset, with hand-computed expectations.
module tb_id_issue_stage;

  localparam int DATA_W  = 32;
  localparam int NUM_BYP = 3;
  localparam int DRAIN   = 4;

  logic                      CLK = 1'b0;
  logic                      RESET;
  logic                      in_valid;
  logic [31:0]               in_instr;
  logic [DATA_W-1:0]         in_pc;
  logic [4:0]                in_rs, in_rt, in_wreg;
  logic                      in_uses_rs, in_uses_rt;
  logic                      in_regwrite, in_memread, in_serialize;
  logic [DATA_W-1:0]         rf_rs_data, rf_rt_data;
  logic [5*NUM_BYP-1:0]      byp_reg;
  logic [DATA_W*NUM_BYP-1:0] byp_data;
  logic [NUM_BYP-1:0]        byp_valid;
  logic                      exe_ready, flush;
  logic                      stall;
  logic                      out_valid, out_regwrite, out_memread;
  logic [31:0]               out_instr;
  logic [DATA_W-1:0]         out_pc, out_opa, out_opb;
  logic [4:0]                out_wreg;
  logic                      sys_pulse;

  int checkCount = 0;
  int failCount  = 0;

  id_issue_stage #(.DATA_W(DATA_W), .NUM_BYP(NUM_BYP), .DRAIN(DRAIN)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs(in_rs), .in_rt(in_rt), .in_wreg(in_wreg),
    .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt),
    .in_regwrite(in_regwrite), .in_memread(in_memread), .in_serialize(in_serialize),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .byp_reg(byp_reg), .byp_data(byp_data), .byp_valid(byp_valid),
    .exe_ready(exe_ready), .flush(flush), .stall(stall),
    .out_valid(out_valid), .out_regwrite(out_regwrite), .out_memread(out_memread),
    .out_instr(out_instr), .out_pc(out_pc), .out_opa(out_opa), .out_opb(out_opb),
    .out_wreg(out_wreg), .sys_pulse(sys_pulse)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] wreg, input logic uses_rs,
                               input logic uses_rt, input logic regwrite,
                               input logic memread, input logic serialize);
    in_valid     = valid;
    in_pc        = pc;
    in_instr     = {16'hC0DE, pc[15:0]};
    in_rs        = rs;
    in_rt        = rt;
    in_wreg      = wreg;
    in_uses_rs   = uses_rs;
    in_uses_rt   = uses_rt;
    in_regwrite  = regwrite;
    in_memread   = memread;
    in_serialize = serialize;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; exe_ready = 1'b1; flush = 1'b0;
    rf_rs_data = 32'h99; rf_rt_data = 32'h77;
    byp_reg = '0; byp_data = '0; byp_valid = '0;
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_pc", 64'(out_pc), 64'd0);
    checkOutput("reset_sys_pulse", 64'(sys_pulse), 64'd0);
    checkOutput("reset_stall", 64'(stall), 64'd0);
    #4 RESET = 1'b0;
    step();

    byp_reg   = {5'd5, 5'd5, 5'd5};
    byp_data  = {32'h33, 32'h22, 32'h11};
    byp_valid = 3'b111;
    applyStimulus(1, 32'h40, 5, 7, 3, 1, 1, 1, 0, 0);
    step();
    checkOutput("byp_prio_opa", 64'(out_opa), 64'h11);
    checkOutput("byp_rf_opb", 64'(out_opb), 64'h77);
    checkOutput("byp_valid", 64'(out_valid), 64'd1);
    checkOutput("byp_regwrite", 64'(out_regwrite), 64'd1);
    byp_valid = 3'b000;
    byp_reg   = {5'd5, 5'd7, 5'd5};
    applyStimulus(1, 32'h44, 5, 7, 0, 1, 1, 1, 0, 0);
    step();
    checkOutput("byp_none_opa", 64'(out_opa), 64'h99);
    checkOutput("byp_none_opb", 64'(out_opb), 64'h77);
    checkOutput("wreg0_regwrite", 64'(out_regwrite), 64'd0);
    byp_valid = 3'b110;
    applyStimulus(1, 32'h48, 5, 7, 3, 1, 1, 1, 0, 0);
    step();
    checkOutput("byp_idx1_opb", 64'(out_opb), 64'h22);
    checkOutput("byp_idx2_opa", 64'(out_opa), 64'h33);
    byp_reg = '0; byp_valid = 3'b111;
    applyStimulus(1, 32'h4C, 0, 0, 3, 1, 1, 1, 0, 0);
    step();
    checkOutput("r0_opa", 64'(out_opa), 64'd0);
    checkOutput("r0_opb", 64'(out_opb), 64'd0);
    byp_valid = 3'b000;

    // Load-use on rs: one bubble, then the dependent add issues.
    applyStimulus(1, 32'h80, 1, 0, 8, 1, 0, 1, 1, 0);
    step();
    checkOutput("lw_memread", 64'(out_memread), 64'd1);
    applyStimulus(1, 32'h84, 8, 2, 9, 1, 1, 1, 0, 0);
    #1 checkOutput("lu_stall", 64'(stall), 64'd1);
    step();
    checkOutput("lu_bubble", 64'(out_valid), 64'd0);
    checkOutput("lu_stall_gone", 64'(stall), 64'd0);
    step();
    checkOutput("lu_issue_pc", 64'(out_pc), 64'h84);
    applyStimulus(1, 32'h88, 1, 0, 8, 1, 0, 1, 1, 0);
    step();
    applyStimulus(1, 32'h8C, 2, 8, 9, 1, 1, 1, 0, 0);
    #1 checkOutput("lu_rt_stall", 64'(stall), 64'd1);
    applyStimulus(1, 32'h8C, 8, 2, 9, 0, 1, 1, 0, 0);
    #1 checkOutput("lu_unused_stall", 64'(stall), 64'd0);
    step();
    checkOutput("lu_unused_issue", 64'(out_pc), 64'h8C);
    checkOutput("lu_unused_valid", 64'(out_valid), 64'd1);

    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 checkOutput("sys_pre_stall", 64'(stall), 64'd0);
    step();
    applyStimulus(1, 32'h104, 1, 2, 3, 1, 1, 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      checkOutput($sformatf("drain_stall_%0d", k), 64'(stall), 64'(k <= 4));
      checkOutput($sformatf("drain_valid_%0d", k), 64'(out_valid), 64'(k == 1));
      checkOutput($sformatf("drain_pulse_%0d", k), 64'(sys_pulse), 64'(k == 4));
      step();
    end
    checkOutput("drain_next_valid", 64'(out_valid), 64'd1);
    checkOutput("drain_next_pc", 64'(out_pc), 64'h104);

    // Backpressure holds the issued bundle; nothing lost or duplicated.
    applyStimulus(1, 32'h200, 1, 2, 3, 1, 1, 1, 0, 0);
    step();
    applyStimulus(1, 32'h204, 1, 2, 3, 1, 1, 1, 0, 0);
    exe_ready = 1'b0;
    #1 checkOutput("bp_stall", 64'(stall), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput($sformatf("bp_hold_pc_%0d", k), 64'(out_pc), 64'h200);
      checkOutput($sformatf("bp_hold_valid_%0d", k), 64'(out_valid), 64'd1);
    end
    exe_ready = 1'b1;
    step();
    checkOutput("bp_release_pc", 64'(out_pc), 64'h204);
    applyStimulus(1, 32'h208, 1, 2, 3, 1, 1, 1, 0, 0);
    step();
    checkOutput("bp_next_pc", 64'(out_pc), 64'h208);

    applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    applyStimulus(1, 32'h304, 1, 2, 3, 1, 1, 1, 0, 0);
    step();
    flush = 1'b1;
    #1 checkOutput("flush_pre_stall", 64'(stall), 64'd1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_pulse", 64'(sys_pulse), 64'd0);
    checkOutput("flush_stall", 64'(stall), 64'd0);
    exe_ready = 1'b0;
    #1 checkOutput("flush_stall_ready", 64'(stall), 64'd1);
    exe_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput($sformatf("flush_no_pulse_%0d", k), 64'(sys_pulse), 64'd0);
    end

    applyStimulus(1, 32'h400, 1, 2, 3, 1, 1, 1, 0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush_accept_drop", 64'(out_valid), 64'd0);

    applyStimulus(1, 32'h500, 1, 2, 9, 1, 1, 1, 1, 0);
    step();
    checkOutput("pre_reset_valid", 64'(out_valid), 64'd1);
    #2 RESET = 1'b1;
    #1;
    checkOutput("async_reset_valid", 64'(out_valid), 64'd0);
    checkOutput("async_reset_pc", 64'(out_pc), 64'd0);
    checkOutput("async_reset_regwrite", 64'(out_regwrite), 64'd0);
    checkOutput("async_reset_memread", 64'(out_memread), 64'd0);
    #1 RESET = 1'b0;
    applyStimulus(1, 32'h600, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    in_valid = 1'b0;
    step();
    #2 RESET = 1'b1;
    #1;
    checkOutput("reset_drain_stall", 64'(stall), 64'd0);
    #1 RESET = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput($sformatf("reset_drain_pulse_%0d", k), 64'(sys_pulse), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
